// File: rtl/step_sequencer.sv
// Drum step sequencer: DRUM_COUNT one-bit-per-step patterns played at a programmable tempo,
// with a single pending slot so pattern edits made while playing land cleanly on the loop wrap.
module step_sequencer #(
    parameter int PATTERN_WIDTH = 8,
    parameter int STEP_WIDTH    = 3,
    parameter int DRUM_COUNT    = 5,
    parameter int SEL_WIDTH     = 3,
    parameter int TEMPO_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i_n,
    input  logic [TEMPO_WIDTH-1:0]   tempo_i,
    input  logic [PATTERN_WIDTH-1:0] pattern_i,
    input  logic [SEL_WIDTH-1:0]     drum_sel_i,
    input  logic                     load_valid_i,
    output logic                     load_ready_o,
    output logic                     load_err_o,
    output logic [DRUM_COUNT-1:0]    trig_o,
    output logic [STEP_WIDTH-1:0]    step_o,
    output logic                     running_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [STEP_WIDTH-1:0] LAST_STEP  = STEP_WIDTH'(PATTERN_WIDTH - 1);
    localparam logic [SEL_WIDTH:0]    DRUM_LIMIT = (SEL_WIDTH + 1)'(DRUM_COUNT);

    state_t                   state;
    logic [PATTERN_WIDTH-1:0] active [DRUM_COUNT];
    logic [PATTERN_WIDTH-1:0] eff    [DRUM_COUNT];
    logic [PATTERN_WIDTH-1:0] pend_pattern;
    logic [SEL_WIDTH-1:0]     pend_sel;
    logic                     pending;
    logic [TEMPO_WIDTH-1:0]   counter;

    logic                     accept;
    logic                     sel_ok;
    logic                     stopping;
    logic                     at_step;
    logic                     wrap;
    logic                     direct;
    logic                     commit;
    logic [STEP_WIDTH-1:0]    step_next;
    logic [DRUM_COUNT-1:0]    trig_next;

    assign load_ready_o = !pending;
    assign accept       = load_valid_i && !pending;
    assign sel_ok       = {1'b0, drum_sel_i} < DRUM_LIMIT;
    assign stopping     = (state == RUN) && en_i_n;
    assign at_step      = (state == RUN) && !en_i_n && (counter == '0);
    assign wrap         = at_step && (step_o == LAST_STEP);
    assign step_next    = ((state == IDLE) || wrap) ? '0 : step_o + 1'b1;

    // Loads go straight to the active patterns whenever no step in the middle of the loop
    // could observe a half-updated pattern: while idle, when stopping, and on the wrap edge.
    assign direct = (state == IDLE) || stopping || wrap;
    assign commit = pending && (stopping || wrap);

    // Pattern set as it stands after this edge; the new step's triggers are read from it.
    always_comb begin
        for (int d = 0; d < DRUM_COUNT; d++) begin
            eff[d] = active[d];
            if (commit && (pend_sel == SEL_WIDTH'(d))) begin
                eff[d] = pend_pattern;
            end else if (accept && sel_ok && direct && (drum_sel_i == SEL_WIDTH'(d))) begin
                eff[d] = pattern_i;
            end
            trig_next[d] = eff[d][step_next];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            running_o    <= 1'b0;
            step_o       <= '0;
            counter      <= '0;
            trig_o       <= '0;
            load_err_o   <= 1'b0;
            pending      <= 1'b0;
            pend_pattern <= '0;
            pend_sel     <= '0;
            for (int d = 0; d < DRUM_COUNT; d++) begin
                active[d] <= '0;
            end
        end else begin
            load_err_o <= accept && !sel_ok;
            for (int d = 0; d < DRUM_COUNT; d++) begin
                active[d] <= eff[d];
            end

            if (accept && sel_ok && !direct) begin
                pending      <= 1'b1;
                pend_pattern <= pattern_i;
                pend_sel     <= drum_sel_i;
            end else if (commit) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!en_i_n) begin
                        state     <= RUN;
                        running_o <= 1'b1;
                        step_o    <= '0;
                        counter   <= tempo_i;
                        trig_o    <= trig_next;
                    end
                end
                RUN: begin
                    if (en_i_n) begin
                        state     <= IDLE;
                        running_o <= 1'b0;
                        step_o    <= '0;
                        counter   <= '0;
                        trig_o    <= '0;
                    end else if (counter != '0) begin
                        counter <= counter - 1'b1;
                        trig_o  <= '0;
                    end else begin
                        step_o  <= step_next;
                        counter <= tempo_i;
                        trig_o  <= trig_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer; each task covers one scenario.
module tb_step_sequencer;

    logic       clk;
    logic       rst;
    logic       en_i_n;
    logic [15:0] tempo_i;
    logic [7:0] pattern_i;
    logic [2:0] drum_sel_i;
    logic       load_valid_i;
    logic       load_ready_o;
    logic       load_err_o;
    logic [4:0] trig_o;
    logic [2:0] step_o;
    logic       running_o;

    int checks = 0;
    int errors = 0;

    step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en_i_n       (en_i_n),
        .tempo_i      (tempo_i),
        .pattern_i    (pattern_i),
        .drum_sel_i   (drum_sel_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_err_o   (load_err_o),
        .trig_o       (trig_o),
        .step_o       (step_o),
        .running_o    (running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        en_i_n       = 1'b1;
        tempo_i      = '0;
        pattern_i    = '0;
        drum_sel_i   = '0;
        load_valid_i = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic idle_load(input logic [2:0] sel, input logic [7:0] pat);
        load_valid_i = 1'b1;
        drum_sel_i   = sel;
        pattern_i    = pat;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] tempo);
        tempo_i = tempo;
        en_i_n  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        en_i_n       = 1'b1;
        tempo_i      = '0;
        pattern_i    = '0;
        drum_sel_i   = '0;
        load_valid_i = 1'b0;
        #2;
        checks++;
        if (trig_o !== 5'b0 || step_o !== 3'd0 || running_o !== 1'b0 ||
            load_err_o !== 1'b0 || load_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_values: trig=%b step=%0d run=%b err=%b ready=%b expected 00000 0 0 0 1",
                     trig_o, step_o, running_o, load_err_o, load_ready_o);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] p2;
        logic [2:0] exp_step;
        logic [4:0] exp_trig;
        p2 = 8'b1000_0001;
        do_reset();
        tempo_i = 16'd3;
        idle_load(3'd2, p2);
        checks++;
        if (load_ready_o !== 1'b1 || running_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle_load: ready=%b run=%b expected 1 0", load_ready_o, running_o);
        end
        start_run(16'd3);
        checks++;
        if (trig_o !== 5'b00100 || step_o !== 3'd0 || running_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_start: trig=%b step=%0d run=%b expected 00100 0 1",
                     trig_o, step_o, running_o);
        end
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_step = 3'((i / 4) % 8);
            exp_trig = (i % 4 == 0) ? {2'b00, p2[exp_step], 2'b00} : 5'b0;
            checks++;
            if (trig_o !== exp_trig || step_o !== exp_step) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d: trig=%b step=%0d expected %b %0d",
                         i, trig_o, step_o, exp_trig, exp_step);
            end
        end
    endtask

    task automatic test_load_during_run();
        logic [7:0] p0;
        logic [7:0] p2;
        logic [2:0] exp_step;
        logic [4:0] exp_trig;
        logic       exp_ready;
        p2 = 8'b1000_0001;
        do_reset();
        idle_load(3'd2, p2);
        start_run(16'd3);
        for (int i = 1; i <= 40; i++) begin
            tick();
            p0        = (i >= 32) ? 8'hFF : 8'h00;
            exp_step  = 3'((i / 4) % 8);
            exp_trig  = (i % 4 == 0) ? {2'b00, p2[exp_step], 1'b0, p0[exp_step]} : 5'b0;
            exp_ready = !(i >= 9 && i < 32);
            checks++;
            if (trig_o !== exp_trig || step_o !== exp_step || load_ready_o !== exp_ready) begin
                errors++;
                $display("[TB] FAIL run_load_cycle%0d: trig=%b step=%0d ready=%b expected %b %0d %b",
                         i, trig_o, step_o, load_ready_o, exp_trig, exp_step, exp_ready);
            end
            if (i == 8) begin
                load_valid_i = 1'b1;
                drum_sel_i   = 3'd0;
                pattern_i    = 8'hFF;
            end
            if (i == 9) pattern_i = 8'h00;
            if (i == 20) load_valid_i = 1'b0;
        end
    endtask

    task automatic test_wrap_load();
        logic [4:0] exp_trig;
        do_reset();
        start_run(16'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_trig = (i == 8) ? 5'b00010 : 5'b0;
            checks++;
            if (trig_o !== exp_trig || step_o !== 3'(i % 8) || load_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_load_cycle%0d: trig=%b step=%0d ready=%b expected %b %0d 1",
                         i, trig_o, step_o, load_ready_o, exp_trig, i % 8);
            end
            if (i == 7) begin
                load_valid_i = 1'b1;
                drum_sel_i   = 3'd1;
                pattern_i    = 8'h01;
            end
            if (i == 8) load_valid_i = 1'b0;
        end
    endtask

    task automatic test_bad_sel();
        logic [7:0] p3;
        logic [2:0] exp_step;
        logic [4:0] exp_trig;
        logic       exp_err;
        p3 = 8'h55;
        do_reset();
        idle_load(3'd3, p3);
        idle_load(3'd7, 8'hFF);
        checks++;
        if (load_err_o !== 1'b1 || load_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_sel_idle_pulse: err=%b ready=%b expected 1 1", load_err_o, load_ready_o);
        end
        tick();
        checks++;
        if (load_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_sel_idle_clear: err=%b expected 0", load_err_o);
        end
        start_run(16'd0);
        checks++;
        if (trig_o !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL bad_sel_start: trig=%b expected 01000", trig_o);
        end
        load_valid_i = 1'b1;
        drum_sel_i   = 3'd5;
        pattern_i    = 8'hFF;
        for (int i = 1; i <= 9; i++) begin
            tick();
            load_valid_i = 1'b0;
            exp_step = 3'(i % 8);
            exp_trig = {1'b0, p3[exp_step], 3'b000};
            exp_err  = (i == 1);
            checks++;
            if (trig_o !== exp_trig || load_err_o !== exp_err || load_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bad_sel_run_cycle%0d: trig=%b err=%b ready=%b expected %b %b 1",
                         i, trig_o, load_err_o, load_ready_o, exp_trig, exp_err);
            end
        end
    endtask

    task automatic test_stop_pending();
        do_reset();
        idle_load(3'd2, 8'b1000_0001);
        start_run(16'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 2 && i <= 5) begin
                checks++;
                if (load_ready_o !== 1'b0 || trig_o[4] !== 1'b0 || step_o !== 3'(i)) begin
                    errors++;
                    $display("[TB] FAIL stop_pending_cycle%0d: ready=%b trig4=%b step=%0d expected 0 0 %0d",
                             i, load_ready_o, trig_o[4], step_o, i);
                end
            end
            if (i == 1) begin
                load_valid_i = 1'b1;
                drum_sel_i   = 3'd4;
                pattern_i    = 8'hFF;
            end
            if (i == 2) load_valid_i = 1'b0;
            if (i == 5) en_i_n = 1'b1;
        end
        checks++;
        if (running_o !== 1'b0 || step_o !== 3'd0 || trig_o !== 5'b0 || load_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_pending_idle: run=%b step=%0d trig=%b ready=%b expected 0 0 00000 1",
                     running_o, step_o, trig_o, load_ready_o);
        end
        start_run(16'd0);
        checks++;
        if (trig_o !== 5'b10100) begin
            errors++;
            $display("[TB] FAIL stop_pending_commit: trig=%b expected 10100", trig_o);
        end
    endtask

    task automatic test_tempo_change();
        logic [2:0] exp_step [1:5];
        exp_step = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        do_reset();
        idle_load(3'd0, 8'hFF);
        start_run(16'd2);
        tempo_i = 16'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (step_o !== exp_step[i] || trig_o[0] !== (i >= 3)) begin
                errors++;
                $display("[TB] FAIL tempo_change_cycle%0d: step=%0d trig0=%b expected %0d %b",
                         i, step_o, trig_o[0], exp_step[i], (i >= 3));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        idle_load(3'd0, 8'hFF);
        start_run(16'd0);
        load_valid_i = 1'b1;
        drum_sel_i   = 3'd1;
        pattern_i    = 8'hFF;
        tick();
        load_valid_i = 1'b0;
        tick();
        tick();
        checks++;
        if (trig_o !== 5'b00001 || step_o !== 3'd3 || load_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_pre: trig=%b step=%0d ready=%b expected 00001 3 0",
                     trig_o, step_o, load_ready_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (trig_o !== 5'b0 || step_o !== 3'd0 || running_o !== 1'b0 ||
            load_err_o !== 1'b0 || load_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_assert: trig=%b step=%0d run=%b err=%b ready=%b expected 00000 0 0 0 1",
                     trig_o, step_o, running_o, load_err_o, load_ready_o);
        end
        en_i_n = 1'b1;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (trig_o !== 5'b0 || running_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_release_cycle%0d: trig=%b run=%b expected 00000 0", i, trig_o, running_o);
            end
        end
        start_run(16'd0);
        checks++;
        if (trig_o !== 5'b0 || running_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_restart: trig=%b run=%b expected 00000 1", trig_o, running_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_during_run();
        test_wrap_load();
        test_bad_sel();
        test_stop_pending();
        test_tempo_change();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
